seven_seg_scan_ctrl: RTL
========================

// Module: seven_seg_scan_ctrl
// PURPOSE
//  Time-multiplexes four BCD digits onto the shared 7-seg decoder + anode driver on the board.
//  Drives the decoder's digit-index/nibble inputs and a blank flag; top level ORs blank into all anodes.
//  Double-buffered digit load (frame-aligned update), anti-ghost gap, leading-zero suppression.
// PARAMETERS
//  REFRESH_DIV   100000  clk cycles each digit is lit (SHOW slot); >=1
//  BLANK_CYCLES  1000    clk cycles all anodes off between digits (GAP); 0 = no gap
// PORTS
//  clk          in   1   system clock, rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  enable       in   1   1 = scan running; 0 = display dark
//  load         in   1   1-cycle strobe: capture digits_in
//  digits_in    in   16  BCD, [15:12]=digit 3 (MSD) .. [3:0]=digit 0 (LSD)
//  lz_suppress  in   1   1 = blank leading zeros (digit 0 never suppressed)
//  digit_sel    out  2   digit index to decoder enable input
//  digit_val    out  4   nibble to decoder number input
//  digit_blank  out  1   1 = all anodes must be off this cycle
//  frame_done   out  1   1-cycle pulse at end of digit-3 slot (incl. its GAP)
//  pending      out  1   shadow holds data not yet displayed
// BEHAVIOUR
//  Reset: digit_sel=0, digit_val=0, digit_blank=1, frame_done=0, pending=0,
//   shadow=0, active=0, counter=0, state=IDLE.
//  All outputs registered; 1 clk from state/counter change to outputs.
//  States: IDLE, SHOW, GAP. One counter cnt, cleared on every state/digit change.
//   IDLE: blank=1, sel=0. enable=1 -> SHOW digit 0 (frame boundary).
//   SHOW: blank=mask[sel]; cnt==REFRESH_DIV-1 -> GAP (or straight to next digit if BLANK_CYCLES=0).
//   GAP: blank=1, sel held; cnt==BLANK_CYCLES-1 -> SHOW sel+1 (mod 4).
//   Leaving sel=3 slot: frame_done=1 for one cycle; this is a frame boundary.
//   enable=0 in any state -> IDLE next cycle, cnt cleared; no frame_done.
//  Load/update:
//   load=1 -> shadow<=digits_in, pending<=1.
//   Frame boundary: active<=shadow, pending<=0. If load coincides with boundary,
//    active<=digits_in directly, shadow<=digits_in, pending=0 (newest data wins).
//   active never changes mid-frame; back-to-back loads: last one wins.
//  digit_val = active nibble for sel. Blank mask (digit_blank=1 in SHOW) when:
//   nibble >9 (decoder undefined for 10-15), or lz_suppress and all nibbles from digit 3
//   down to sel are 0 and sel!=0. 0000 with lz_suppress shows a single "0" on digit 0.
//  Reset mid-slot: immediate return to reset values; shadow contents lost.
//  lz_suppress/enable are synchronous inputs; lz_suppress takes effect next cycle.
// STRUCTURE
//  Package seven_seg_pkg: state enum (IDLE/SHOW/GAP), NUM_DIGITS=4, MAX_BCD=4'd9,
//   ANODE_OFF=4'b1111.
//  Sub-module seven_seg_blank_mask: combinational, active[15:0]+lz_suppress -> mask[3:0].
//  Counter width = $clog2(max(REFRESH_DIV,BLANK_CYCLES,2)).
// TESTING (bench params REFRESH_DIV=4, BLANK_CYCLES=2)
//  Reset release, enable=1, load 16'h1234 -> per digit 4 clk lit, 2 clk blank; sel 0..3
//   with val 4,3,2,1; frame_done pulses every 24 clk.
//  Load 16'h5678 mid-frame -> pending=1, digits still 1234 until frame_done; next
//   frame shows 8,7,6,5, pending=0.
//  lz_suppress=1, load 16'h0007 -> digits 3,2,1 blank in SHOW, digit 0 shows 7;
//   load 16'h0000 -> only digit 0 lit with 0.
//  Load 16'h9A0B -> digit 0 (B) and digit 2 (A) blank, digits 1 (0), 3 (9) lit.
//  enable 1->0 during digit 2 SHOW -> next cycle blank=1, sel=0, no frame_done;
//   re-enable -> restarts at digit 0 with shadow contents.
//  BLANK_CYCLES=0 build -> digits abut, frame_done every 16 clk; rst_n low mid-GAP
//   -> outputs at reset values asynchronously.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared types and constants for the 7-seg scan controller
package seven_seg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int         NUM_DIGITS = 4;
    localparam logic [3:0] MAX_BCD    = 4'd9;
    localparam logic [3:0] ANODE_OFF  = 4'b1111;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seven_seg_blank_mask.sv
// rtl/seven_seg_blank_mask.sv - per-digit blank mask: invalid BCD and leading-zero suppression
module seven_seg_blank_mask
    import seven_seg_pkg::*;
(
    input  logic [15:0] active,
    input  logic        lz_suppress,
    output logic [3:0]  mask
);

    logic lead;

    // Walk from the MSD down; lead stays set while every nibble so far is zero.
    always_comb begin
        mask = '0;
        lead = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lead    = lead & (active[i*4 +: 4] == 4'd0);
            mask[i] = (active[i*4 +: 4] > MAX_BCD) || (lz_suppress && lead && (i != 0));
        end
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - four-digit 7-seg scan controller with double-buffered digits
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic        lz_suppress,
    output logic [1:0]  digit_sel,
    output logic [3:0]  digit_val,
    output logic        digit_blank,
    output logic        frame_done,
    output logic        pending
);

    localparam int CNT_SPAN = max3(REFRESH_DIV, BLANK_CYCLES, 2);
    localparam int CW       = $clog2(CNT_SPAN);

    localparam logic [CW-1:0] SHOW_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    state_t        state, state_n;
    logic [1:0]    sel, sel_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [15:0]   shadow, active;
    logic          frame_end;
    logic          boundary;
    logic [3:0]    mask;
    logic [3:0]    blank_vec;
    logic [3:0]    cur_nib;

    seven_seg_blank_mask u_mask (
        .active      (active),
        .lz_suppress (lz_suppress),
        .mask        (mask)
    );

    always_comb begin
        state_n   = state;
        sel_n     = sel;
        cnt_n     = cnt + CW'(1);
        frame_end = 1'b0;
        boundary  = 1'b0;
        if (!enable) begin
            state_n = IDLE;
            sel_n   = 2'd0;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n  = SHOW;
                    sel_n    = 2'd0;
                    cnt_n    = '0;
                    boundary = 1'b1;
                end
                SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        cnt_n = '0;
                        if (BLANK_CYCLES == 0) begin
                            sel_n     = sel + 2'd1;
                            frame_end = (sel == 2'd3);
                        end else begin
                            state_n = GAP;
                        end
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        state_n   = SHOW;
                        sel_n     = sel + 2'd1;
                        cnt_n     = '0;
                        frame_end = (sel == 2'd3);
                    end
                end
                default: begin
                    state_n = IDLE;
                    sel_n   = 2'd0;
                    cnt_n   = '0;
                end
            endcase
            boundary = boundary | frame_end;
        end
    end

    // Outside SHOW every anode is dark regardless of the digit contents.
    always_comb begin
        blank_vec = (state == SHOW) ? mask : ANODE_OFF;
        cur_nib   = active[{sel, 2'b00} +: 4];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel   <= 2'd0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            sel   <= sel_n;
            cnt   <= cnt_n;
        end
    end

    // A load landing on a frame boundary goes straight to the active buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
        end else if (boundary) begin
            active  <= load ? digits_in : shadow;
            shadow  <= load ? digits_in : shadow;
            pending <= 1'b0;
        end else if (load) begin
            shadow  <= digits_in;
            pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_sel   <= 2'd0;
            digit_val   <= 4'd0;
            digit_blank <= 1'b1;
            frame_done  <= 1'b0;
        end else begin
            digit_sel   <= sel;
            digit_val   <= cur_nib;
            digit_blank <= blank_vec[sel];
            frame_done  <= frame_end;
        end
    end

endmodule
